stream_rr_arbiter: RTL and testbench



---
 rtl/codec_cmn_pkg.sv | 11 +
 rtl/rr_pick.sv | 34 +++
 rtl/stream_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cmn_pkg.sv
// Shared types and helpers for the entropy-coding path schedulers.
package codec_cmn_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Index width for n items; never returns 0 so ports stay legal for n<=2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import codec_cmn_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] winner
);

    localparam int SW = IDX_WIDTH + 1;

    always_comb begin
        logic [SW-1:0] pos;
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + SW'(k);
            if (pos >= SW'(NUM_REQ)) begin
                pos = pos - SW'(NUM_REQ);
            end
            if (!found && req[pos[IDX_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = pos[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with packet locking and a BURST_MAX beat limit.
// Define STREAM_RR_ARBITER_OUT_REG_EN to register the output through a 2-entry skid buffer.
module stream_rr_arbiter
    import codec_cmn_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    input  logic [NUM_REQ-1:0]            in_vld,
    output logic [NUM_REQ-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic                          busy
);

    localparam int CNT_WIDTH = $clog2(BURST_MAX) + 1;

    arb_state_t           state, state_nxt;
    logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [CNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 own_vld, own_last, acc_rdy, accept, release_now;
    logic [DATA_WIDTH-1:0] own_data;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req    (in_vld),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .winner (pick_idx)
    );

    assign busy        = (state == ARB_GRANT);
    assign own_vld     = in_vld[grant_idx];
    assign own_last    = in_last[grant_idx];
    assign own_data    = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign accept      = busy && own_vld && acc_rdy;
    assign release_now = accept && (own_last || (beat_cnt == CNT_WIDTH'(BURST_MAX-1)));

    always_comb begin
        in_rdy = '0;
        if (busy) begin
            in_rdy[grant_idx] = acc_rdy;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_idx;
        beat_cnt_nxt = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    state_nxt    = ARB_IDLE;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (grant_idx == IDX_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            grant_idx <= grant_nxt;
        end
    end

`ifdef STREAM_RR_ARBITER_OUT_REG_EN
    // Ready comes from the registered fill level, so out_rdy never reaches in_rdy.
    logic [DATA_WIDTH:0] skid_mem [2];
    logic                skid_wr, skid_rd, skid_pop;
    logic [1:0]          skid_cnt;

    assign acc_rdy  = (skid_cnt != 2'd2);
    assign skid_pop = out_vld && out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_wr  <= 1'b0;
            skid_rd  <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (accept) begin
                skid_wr <= ~skid_wr;
            end
            if (skid_pop) begin
                skid_rd <= ~skid_rd;
            end
            if (accept && !skid_pop) begin
                skid_cnt <= skid_cnt + 2'd1;
            end else if (skid_pop && !accept) begin
                skid_cnt <= skid_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            skid_mem[skid_wr] <= {own_last, own_data};
        end
    end

    assign out_vld             = (skid_cnt != 2'd0);
    assign {out_last, out_data} = skid_mem[skid_rd];
`else
    assign acc_rdy  = out_rdy;
    assign out_vld  = busy && own_vld;
    assign out_last = busy && own_last;
    assign out_data = busy ? own_data : '0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter; a transaction-level
// arbitration model predicts every beat and the handshake/grant outputs.
module tb_stream_rr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_MAX  = 4;
    localparam int IDX_WIDTH  = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_last, in_vld, in_rdy;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last, out_vld, out_rdy, busy;
    logic [IDX_WIDTH-1:0]          grant_idx;

    stream_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_MAX  (BURST_MAX),
        .IDX_WIDTH  (IDX_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    beat_t exp_q[$];
    int    ids_seen[$];
    int    exp_ids[$];
    int    checks   = 0;
    int    failures = 0;

    int    cfg_pkts[NUM_REQ];
    int    cfg_len[NUM_REQ];
    int    cfg_gap, cfg_rdy_mode, phase;

    int    started[NUM_REQ], rem[NUM_REQ], seq[NUM_REQ];
    int    drv_phase;
    logic  drv_idle;

    logic              m_granted, exp_busy, exp_vld;
    int                m_owner, m_ptr, m_beats, m_occ, exp_owner;
    logic [NUM_REQ-1:0] exp_rdy;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkIds(input string name);
        checkOutput({name, "_count"}, ids_seen.size(), exp_ids.size());
        for (int k = 0; k < exp_ids.size() && k < ids_seen.size(); k++) begin
            checkOutput(name, ids_seen[k], exp_ids[k]);
        end
    endtask

    // Packets per requester and packet lengths are packed one nibble per requester (len 0 = random).
    task automatic applyStimulus(input logic [15:0] pk, input logic [15:0] ln, input int gap,
                                 input int rdy_mode, input int budget);
        int waited;
        @(negedge clk); #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            cfg_pkts[i] = int'(pk[4*i +: 4]);
            cfg_len[i]  = int'(ln[4*i +: 4]);
        end
        cfg_gap      = gap;
        cfg_rdy_mode = rdy_mode;
        phase++;
        repeat (2) @(negedge clk);
        waited = 0;
        while (!(drv_idle && !m_granted && m_occ == 0 && exp_q.size() == 0) && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        #2;
        checkOutput("phase_done", 32'(waited < budget), 32'd1);
    endtask

    // Requesters: each beat carries {id, sequence}; valid only drops after an accepted beat.
    initial begin : driver
        logic [NUM_REQ-1:0] acc;
        in_vld    = '0;
        in_last   = '0;
        in_data   = '0;
        out_rdy   = 1'b0;
        drv_idle  = 1'b1;
        drv_phase = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            started[i] = 0;
            rem[i]     = 0;
            seq[i]     = 0;
        end
        forever begin
            @(negedge clk);
            acc = in_vld & in_rdy;
            @(posedge clk); #1;
            if (phase != drv_phase) begin
                drv_phase = phase;
                for (int i = 0; i < NUM_REQ; i++) started[i] = 0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rst_n) begin
                    in_vld[i]  = 1'b0;
                    rem[i]     = 0;
                    started[i] = cfg_pkts[i];
                end else begin
                    if (acc[i]) begin
                        rem[i]--;
                        seq[i]    = (seq[i] + 1) % 64;
                        in_vld[i] = 1'b0;
                    end
                    if (!in_vld[i]) begin
                        if (rem[i] == 0 && started[i] < cfg_pkts[i]) begin
                            rem[i] = (cfg_len[i] == 0) ? int'($urandom_range(1, 7)) : cfg_len[i];
                            started[i]++;
                        end
                        if (rem[i] > 0 && int'($urandom_range(0, 99)) >= cfg_gap) begin
                            in_vld[i] = 1'b1;
                            in_data[i*DATA_WIDTH +: DATA_WIDTH] = {2'(i), 6'(seq[i])};
                            in_last[i] = (rem[i] == 1);
                        end
                    end
                end
            end
            case (cfg_rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ~out_rdy;
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            drv_idle = (in_vld == '0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (started[i] < cfg_pkts[i] || rem[i] != 0) drv_idle = 1'b0;
            end
        end
    end

    // Reference model: owner search from the pointer, lock until last or BURST_MAX beats.
    always @(negedge clk) begin : model
        logic acc, drn;
        beat_t b;
        if (!rst_n) begin
            m_granted = 1'b0;
            m_owner   = 0;
            m_ptr     = 0;
            m_beats   = 0;
            m_occ     = 0;
            exp_busy  = 1'b0;
            exp_vld   = 1'b0;
            exp_rdy   = '0;
            exp_owner = 0;
            exp_q.delete();
        end else begin
            exp_busy  = m_granted;
            exp_owner = m_owner;
`ifdef STREAM_RR_ARBITER_OUT_REG_EN
            exp_vld = (m_occ > 0);
            exp_rdy = (m_granted && m_occ < 2) ? NUM_REQ'(1) << m_owner : '0;
            acc     = m_granted && in_vld[m_owner] && (m_occ < 2);
            drn     = (m_occ > 0) && out_rdy;
            m_occ   = m_occ + int'(acc) - int'(drn);
`else
            exp_vld = m_granted && in_vld[m_owner];
            exp_rdy = m_granted ? NUM_REQ'(out_rdy) << m_owner : '0;
            acc     = exp_vld && out_rdy;
            drn     = 1'b0;
`endif
            if (acc) begin
                b.data = in_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
                b.last = in_last[m_owner];
                exp_q.push_back(b);
                m_beats++;
                if (b.last || m_beats == BURST_MAX) begin
                    m_granted = 1'b0;
                    m_beats   = 0;
                    m_ptr     = (m_owner + 1) % NUM_REQ;
                end
            end else if (!m_granted) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (in_vld[(m_ptr + k) % NUM_REQ]) begin
                        m_owner   = (m_ptr + k) % NUM_REQ;
                        m_granted = 1'b1;
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        beat_t b;
        #1;
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("out_vld", 32'(out_vld), 32'(exp_vld));
        checkOutput("in_rdy", 32'(in_rdy), 32'(exp_rdy));
        checkOutput("grant_idx", 32'(grant_idx), 32'(exp_owner));
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                b = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(b.data));
                checkOutput("out_last", 32'(out_last), 32'(b.last));
                ids_seen.push_back(int'(out_data[DATA_WIDTH-1 -: 2]));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        rst_n        = 1'b0;
        cfg_gap      = 0;
        cfg_rdy_mode = 0;
        phase        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cfg_pkts[i] = 0;
            cfg_len[i]  = 1;
        end
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_vld", 32'(out_vld), 32'd0);
        checkOutput("reset_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("reset_grant_idx", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;

        repeat (10) @(negedge clk);
        #2;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_out_vld", 32'(out_vld), 32'd0);
        checkOutput("idle_in_rdy", 32'(in_rdy), 32'd0);

        $display("[TB] round robin");
        ids_seen.delete();
        exp_ids = '{0, 1, 2, 3, 0};
        applyStimulus(16'h1112, 16'h1111, 0, 0, 200);
        checkIds("rr_order");

        $display("[TB] burst limit");
        ids_seen.delete();
        exp_ids = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        applyStimulus(16'h0011, 16'h00A3, 0, 0, 300);
        checkIds("burst_order");

        $display("[TB] backpressure and gaps");
        applyStimulus(16'h1001, 16'h6006, 40, 1, 600);

        $display("[TB] pointer wrap");
        ids_seen.delete();
        exp_ids = '{2, 0, 2};
        applyStimulus(16'h0100, 16'h0111, 0, 0, 100);
        applyStimulus(16'h0101, 16'h0111, 0, 0, 100);
        checkIds("wrap_order");

        $display("[TB] async reset mid-packet");
        @(negedge clk); #2;
        for (int i = 0; i < NUM_REQ; i++) begin
            cfg_pkts[i] = (i == 2) ? 1 : 0;
            cfg_len[i]  = 8;
        end
        cfg_gap      = 0;
        cfg_rdy_mode = 0;
        phase++;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_reset_out_vld", 32'(out_vld), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_out_vld", 32'(out_vld), 32'd0);
        checkOutput("async_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ids_seen.delete();
        exp_ids = '{0, 3};
        applyStimulus(16'h1001, 16'h1001, 0, 0, 100);
        checkIds("post_reset_order");

        $display("[TB] random traffic");
        applyStimulus(16'h5555, 16'h0000, 30, 2, 3000);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
